axi4lite_reg_bridge: RTL and testbench
======================================

AXI4LITE_REG_BRIDGE -- requirements
Module: axi4lite_reg_bridge

Interface
REQ-001 SHALL have parameters: BUS_WIDTH, 32, data width; ADDR_WIDTH, 5, byte-address width.
REQ-002 SHALL have port aclk, in, 1, sole clock; all logic on posedge.
REQ-003 SHALL have port areset, in, 1: reset is synchronous and active-high.
REQ-004 SHALL have write-address slave ports: awaddr in ADDR_WIDTH, awprot in 3, awvalid in 1, awready out 1.
REQ-005 SHALL have write-data slave ports: wdata in BUS_WIDTH, wstrb in BUS_WIDTH/8, wvalid in 1, wready out 1.
REQ-006 SHALL have write-response slave ports: bresp out 2, bvalid out 1, bready in 1.
REQ-007 SHALL have read-address slave ports: araddr in ADDR_WIDTH, arprot in 3, arvalid in 1, arready out 1.
REQ-008 SHALL have read-data slave ports: rdata out BUS_WIDTH, rresp out 2, rvalid out 1, rready in 1.
REQ-009 SHALL have reg_addr, out, ADDR_WIDTH, register byte address for the current strobe.
REQ-010 SHALL have reg_wr_en, out, 1, one-cycle write strobe; reg_wr_data, out, BUS_WIDTH; reg_wr_strb, out, BUS_WIDTH/8.
REQ-011 SHALL have reg_rd_en, out, 1, one-cycle read strobe; reg_rd_data, in, BUS_WIDTH, combinationally valid in the reg_rd_en cycle.
REQ-012 SHALL have reg_err, in, 1, sampled only in a strobe cycle; 1 -> SLVERR.

Function
REQ-013 SHALL implement FSM states IDLE, WR_COLLECT, WR_STROBE, WR_RESP, RD_STROBE, RD_RESP; exactly one transaction outstanding.
REQ-014 IDLE: awready=wready=1; AW and W accepted independently; both in the same cycle -> WR_STROBE; only one -> WR_COLLECT, holding it.
REQ-015 WR_COLLECT: the already-accepted channel's ready=0, the other's ready=1; on its handshake -> WR_STROBE.
REQ-016 WR_STROBE: reg_wr_en=1 for exactly one cycle with latched addr/data/strb; bresp latched from reg_err -> WR_RESP.
REQ-017 WR_RESP: bvalid=1, bresp stable until bready; on handshake -> IDLE.
REQ-018 IDLE: arready=1 only when awvalid=0 and wvalid=0; simultaneous AR and AW/W -> write wins, read stalls.
REQ-019 AR handshake -> RD_STROBE: reg_rd_en=1 one cycle; rdata latched from reg_rd_data, rresp from reg_err -> RD_RESP.
REQ-020 RD_RESP: rvalid=1, rdata/rresp stable until rready; on handshake -> IDLE.
REQ-021 Latency: address+data handshake cycle N -> strobe N+1 -> bvalid/rvalid N+2; bready/rready held high sustains one transaction per 3 cycles.
REQ-022 bresp/rresp SHALL be 2'b00 OKAY or 2'b10 SLVERR only; reg_addr unmodified, no alignment.
REQ-023 reg_wr_en and reg_rd_en SHALL never be asserted together.

Reset
REQ-024 areset=1 at posedge: FSM->IDLE; bvalid, rvalid, reg_wr_en, reg_rd_en=0; bresp, rresp, rdata, reg_addr, reg_wr_data, reg_wr_strb=0; awready, wready, arready=0 while areset=1.
REQ-025 Reset mid-transaction SHALL discard the transaction: no strobe and no response issued afterwards.

Configuration
REQ-026 Macro AXI4LITE_REG_BRIDGE_PROT_CHECK_EN defined: access with awprot[0]/arprot[0]=0 (unprivileged) SHALL skip strobe but still pass through the strobe state, responding SLVERR, rdata=0, same latency.
REQ-027 Macro undefined: awprot/arprot ignored; all accesses strobe normally.

Structure
REQ-028 Package axi4lite_reg_pkg SHALL hold the FSM state enum and RESP_OKAY/RESP_SLVERR constants.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 AW 0x04 and W 0xDEADBEEF/strb 0xF same cycle, bready=1 -> reg_wr_en at N+1 with those values, bvalid at N+2, bresp 00.
REQ-031 W at cycle 0, AW 0x08 at cycle 3 -> wready=0 cycles 1-3, single strobe cycle 4, bvalid cycle 5.
REQ-032 AR 0x0C, reg_rd_data 0x12345678, rready low 4 cycles -> rvalid held, rdata stable 0x12345678, rresp 00.
REQ-033 arvalid and awvalid+wvalid same cycle -> write strobe first, read strobe only after B handshake; reg_err=1 on read -> rresp 10.
REQ-034 areset asserted in WR_RESP and in RD_STROBE -> bvalid/rvalid 0 next cycle, no further strobe; with PROT_CHECK_EN, arprot=0 -> no reg_rd_en, rresp 10.

Source files
------------

// File: rtl/axi4lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite to register-strobe bridge.
// Holds the bridge FSM state encoding and the AXI response codes.
package axi4lite_reg_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_STROBE  = 3'd2,
    WR_RESP    = 3'd3,
    RD_STROBE  = 3'd4,
    RD_RESP    = 3'd5
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Map the register file's error flag onto an AXI response code.
  function automatic logic [1:0] resp_from_err(input logic err);
    logic [1:0] resp;
    if (err) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave that turns each bus transaction into a single-cycle
// register read or write strobe. One transaction is outstanding at a time;
// writes take priority over reads when both arrive together.
// Optional build macro AXI4LITE_REG_BRIDGE_PROT_CHECK_EN: unprivileged
// accesses (prot[0]=0) are answered with SLVERR and never reach the registers.
module axi4lite_reg_bridge
  import axi4lite_reg_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [BUS_WIDTH-1:0]    wdata,
  input  logic [BUS_WIDTH/8-1:0]  wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [BUS_WIDTH-1:0]    rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_wr_en,
  output logic [BUS_WIDTH-1:0]    reg_wr_data,
  output logic [BUS_WIDTH/8-1:0]  reg_wr_strb,
  output logic                    reg_rd_en,
  input  logic [BUS_WIDTH-1:0]    reg_rd_data,
  input  logic                    reg_err
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  bridge_state_e state_r;
  bridge_state_e next_s;

  logic                  aw_got_r;
  logic                  w_got_r;
  logic                  aw_prot_ok_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BUS_WIDTH-1:0]  wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic [BUS_WIDTH-1:0]  rdata_r;
  logic [1:0]            bresp_r;
  logic [1:0]            rresp_r;
  logic                  bvalid_r;
  logic                  rvalid_r;
  logic                  wr_en_r;
  logic                  rd_en_r;

  logic awready_s;
  logic wready_s;
  logic arready_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic ar_hs_s;
  logic wr_prot_ok_s;
  logic rd_prot_ok_s;
  logic unused_prot_s;

  // Decide whether an access with the given protection bits may touch the registers.
  function automatic logic prot_allows(input logic [2:0] prot);
    logic ok;
`ifdef AXI4LITE_REG_BRIDGE_PROT_CHECK_EN
    ok = prot[0];
`else
    ok = 1'b1;
`endif
    return ok;
  endfunction

`ifdef AXI4LITE_REG_BRIDGE_PROT_CHECK_EN
  assign unused_prot_s = ^{awprot[2:1], arprot[2:1]};
`else
  assign unused_prot_s = ^{awprot, arprot};
`endif

  // Ready decode: open in IDLE, only the missing channel in WR_COLLECT, closed in reset.
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    arready_s = 1'b0;
    if (areset) begin
      awready_s = 1'b0;
      wready_s  = 1'b0;
      arready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          awready_s = 1'b1;
          wready_s  = 1'b1;
          arready_s = ~awvalid & ~wvalid;
        end
        WR_COLLECT: begin
          awready_s = ~aw_got_r;
          wready_s  = ~w_got_r;
        end
        default: begin
          awready_s = 1'b0;
          wready_s  = 1'b0;
          arready_s = 1'b0;
        end
      endcase
    end
  end

  assign aw_hs_s = awvalid & awready_s;
  assign w_hs_s  = wvalid & wready_s;
  assign ar_hs_s = arvalid & arready_s;

  // A write's protection comes from this cycle's AW beat if present, else the held one.
  assign wr_prot_ok_s = aw_hs_s ? prot_allows(awprot) : aw_prot_ok_r;
  assign rd_prot_ok_s = prot_allows(arprot);

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          next_s = WR_STROBE;
        end else if (aw_hs_s || w_hs_s) begin
          next_s = WR_COLLECT;
        end else if (ar_hs_s) begin
          next_s = RD_STROBE;
        end else begin
          next_s = IDLE;
        end
      end
      WR_COLLECT: begin
        if (aw_hs_s || w_hs_s) begin
          next_s = WR_STROBE;
        end else begin
          next_s = WR_COLLECT;
        end
      end
      WR_STROBE: next_s = WR_RESP;
      WR_RESP: begin
        if (bready) begin
          next_s = IDLE;
        end else begin
          next_s = WR_RESP;
        end
      end
      RD_STROBE: next_s = RD_RESP;
      RD_RESP: begin
        if (rready) begin
          next_s = IDLE;
        end else begin
          next_s = RD_RESP;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Capture address/data, drive registered strobes and build the responses.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_got_r     <= 1'b0;
      w_got_r      <= 1'b0;
      aw_prot_ok_r <= 1'b0;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= {BUS_WIDTH{1'b0}};
      wstrb_r      <= {STRB_WIDTH{1'b0}};
      rdata_r      <= {BUS_WIDTH{1'b0}};
      bresp_r      <= RESP_OKAY;
      rresp_r      <= RESP_OKAY;
      bvalid_r     <= 1'b0;
      rvalid_r     <= 1'b0;
      wr_en_r      <= 1'b0;
      rd_en_r      <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        addr_r       <= awaddr;
        aw_prot_ok_r <= prot_allows(awprot);
      end else if (ar_hs_s) begin
        addr_r <= araddr;
      end
      if (w_hs_s) begin
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      aw_got_r <= (next_s == WR_COLLECT) && (aw_got_r || aw_hs_s);
      w_got_r  <= (next_s == WR_COLLECT) && (w_got_r || w_hs_s);
      // A blocked access still walks through the strobe state, just without a strobe.
      wr_en_r  <= (next_s == WR_STROBE) && wr_prot_ok_s;
      rd_en_r  <= (next_s == RD_STROBE) && rd_prot_ok_s;
      bvalid_r <= (next_s == WR_RESP);
      rvalid_r <= (next_s == RD_RESP);
      if (state_r == WR_STROBE) begin
        bresp_r <= wr_en_r ? resp_from_err(reg_err) : RESP_SLVERR;
      end
      if (state_r == RD_STROBE) begin
        rresp_r <= rd_en_r ? resp_from_err(reg_err) : RESP_SLVERR;
        rdata_r <= rd_en_r ? reg_rd_data : {BUS_WIDTH{1'b0}};
      end
    end
  end

  assign awready     = awready_s;
  assign wready      = wready_s;
  assign arready     = arready_s;
  assign bvalid      = bvalid_r;
  assign bresp       = bresp_r;
  assign rvalid      = rvalid_r;
  assign rresp       = rresp_r;
  assign rdata       = rdata_r;
  assign reg_addr    = addr_r;
  assign reg_wr_en   = wr_en_r;
  assign reg_wr_data = wdata_r;
  assign reg_wr_strb = wstrb_r;
  assign reg_rd_en   = rd_en_r;

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge: a vector table of single
// transactions plus hand-written sequences for split writes, back-pressure,
// write/read arbitration and reset in the middle of a transaction.
module tb_axi4lite_reg_bridge;

  logic        aclk;
  logic        areset;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [4:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_err;

  int checks = 0;
  int errors = 0;

  axi4lite_reg_bridge #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_err(reg_err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        err;
    logic [31:0] rd_data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  function automatic logic prot_ok(input logic [2:0] p);
`ifdef AXI4LITE_REG_BRIDGE_PROT_CHECK_EN
    return p[0];
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  initial begin
    logic        en;
    logic [1:0]  resp;
    logic [31:0] rexp;
    vec_t        v;

    // is_wr addr   data          strb   prot    err   rd_data       resp   rdata
    vecs[0] = '{1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, 32'h0,        2'b00, 32'h0};
    vecs[1] = '{1'b1, 5'h10, 32'h0000A5A5, 4'h3, 3'b001, 1'b1, 32'h0,        2'b10, 32'h0};
    vecs[2] = '{1'b0, 5'h04, 32'h0,        4'h0, 3'b001, 1'b0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 5'h1F, 32'h0,        4'h0, 3'b011, 1'b1, 32'h11112222, 2'b10, 32'h11112222};
    vecs[4] = '{1'b1, 5'h03, 32'h12345678, 4'h8, 3'b000, 1'b0, 32'h0,        2'b00, 32'h0};
    vecs[5] = '{1'b0, 5'h0C, 32'h0,        4'h0, 3'b010, 1'b0, 32'h87654321, 2'b00, 32'h87654321};

    areset = 1'b1; awaddr = 5'h0; awprot = 3'b001; awvalid = 1'b1;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b1; bready = 1'b0;
    araddr = 5'h0; arprot = 3'b001; arvalid = 1'b1; rready = 1'b0;
    reg_rd_data = 32'h0; reg_err = 1'b0;

    // Reset state, with valids asserted to show readies stay low.
    cyc();
    smp();
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_strobes", {30'b0, reg_wr_en, reg_rd_en}, 32'd0);
    chk("rst_regs", {25'b0, reg_addr, bresp}, 32'd0);
    chk("rst_wr_data", reg_wr_data, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    areset = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    cyc();

    // Table of single back-to-back transactions.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      en   = prot_ok(v.prot);
      resp = en ? v.exp_resp : 2'b10;
      rexp = en ? v.exp_rdata : 32'h0;
      reg_err = v.err;
      if (v.is_wr) begin
        awaddr = v.addr; awprot = v.prot; wdata = v.data; wstrb = v.strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        smp();
        chk("v_awready", {31'b0, awready}, 32'd1);
        chk("v_wready", {31'b0, wready}, 32'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        smp();
        chk("v_wr_en", {31'b0, reg_wr_en}, {31'b0, en});
        chk("v_rd_en_idle", {31'b0, reg_rd_en}, 32'd0);
        chk("v_wr_addr", {27'b0, reg_addr}, {27'b0, v.addr});
        chk("v_wr_data", reg_wr_data, v.data);
        chk("v_wr_strb", {28'b0, reg_wr_strb}, {28'b0, v.strb});
        cyc();
        smp();
        chk("v_bvalid", {31'b0, bvalid}, 32'd1);
        chk("v_bresp", {30'b0, bresp}, {30'b0, resp});
        chk("v_wr_en_once", {31'b0, reg_wr_en}, 32'd0);
        cyc();
      end else begin
        araddr = v.addr; arprot = v.prot; reg_rd_data = v.rd_data;
        arvalid = 1'b1; rready = 1'b1;
        smp();
        chk("v_arready", {31'b0, arready}, 32'd1);
        cyc();
        arvalid = 1'b0;
        smp();
        chk("v_rd_en", {31'b0, reg_rd_en}, {31'b0, en});
        chk("v_wr_en_idle", {31'b0, reg_wr_en}, 32'd0);
        chk("v_rd_addr", {27'b0, reg_addr}, {27'b0, v.addr});
        cyc();
        smp();
        chk("v_rvalid", {31'b0, rvalid}, 32'd1);
        chk("v_rdata", rdata, rexp);
        chk("v_rresp", {30'b0, rresp}, {30'b0, resp});
        cyc();
      end
      smp();
      chk("v_valid_drop", {30'b0, bvalid, rvalid}, 32'd0);
      cyc();
    end

    // W first, AW three cycles later: single strobe after AW arrives.
    reg_err = 1'b0; awprot = 3'b001; bready = 1'b1;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    smp();
    chk("split_c0_wready", {31'b0, wready}, 32'd1);
    cyc();
    wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        awaddr = 5'h08; awvalid = 1'b1;
      end
      smp();
      chk("split_wready_low", {31'b0, wready}, 32'd0);
      chk("split_no_strobe", {31'b0, reg_wr_en}, 32'd0);
      chk("split_awready", {31'b0, awready}, 32'd1);
      cyc();
    end
    awvalid = 1'b0;
    smp();
    chk("split_c4_wr_en", {31'b0, reg_wr_en}, 32'd1);
    chk("split_c4_addr", {27'b0, reg_addr}, 32'h08);
    chk("split_c4_data", reg_wr_data, 32'h0BADF00D);
    cyc();
    smp();
    chk("split_c5_bvalid", {31'b0, bvalid}, 32'd1);
    chk("split_c5_single", {31'b0, reg_wr_en}, 32'd0);
    cyc();

    // Read with rready held low: response must hold steady.
    araddr = 5'h0C; arprot = 3'b001; arvalid = 1'b1; rready = 1'b0;
    reg_rd_data = 32'h12345678;
    cyc();
    arvalid = 1'b0;
    smp();
    chk("bp_rd_en", {31'b0, reg_rd_en}, 32'd1);
    cyc();
    reg_rd_data = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("bp_rvalid_held", {31'b0, rvalid}, 32'd1);
      chk("bp_rdata_stable", rdata, 32'h12345678);
      chk("bp_rresp", {30'b0, rresp}, 32'd0);
      chk("bp_arready_low", {31'b0, arready}, 32'd0);
      cyc();
    end
    rready = 1'b1;
    smp();
    chk("bp_rvalid_final", {31'b0, rvalid}, 32'd1);
    cyc();
    smp();
    chk("bp_rvalid_done", {31'b0, rvalid}, 32'd0);
    cyc();
    rready = 1'b0;

    // Write and read arrive together: write first, read after B handshake.
    araddr = 5'h14; arprot = 3'b001; arvalid = 1'b1;
    awaddr = 5'h18; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0; reg_err = 1'b0; reg_rd_data = 32'hA0A0A0A0;
    smp();
    chk("arb_arready_low", {31'b0, arready}, 32'd0);
    chk("arb_awready", {31'b0, awready}, 32'd1);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    smp();
    chk("arb_wr_first", {30'b0, reg_wr_en, reg_rd_en}, 32'd2);
    cyc();
    smp();
    chk("arb_bvalid", {31'b0, bvalid}, 32'd1);
    chk("arb_ar_stall1", {31'b0, arready}, 32'd0);
    cyc();
    smp();
    chk("arb_ar_stall2", {30'b0, arready, reg_rd_en}, 32'd0);
    bready = 1'b1;
    cyc();
    bready = 1'b0; reg_err = 1'b1; rready = 1'b1;
    smp();
    chk("arb_arready_now", {31'b0, arready}, 32'd1);
    chk("arb_no_rd_yet", {31'b0, reg_rd_en}, 32'd0);
    cyc();
    arvalid = 1'b0;
    smp();
    chk("arb_rd_strobe", {30'b0, reg_wr_en, reg_rd_en}, 32'd1);
    chk("arb_rd_addr", {27'b0, reg_addr}, 32'h14);
    cyc();
    smp();
    chk("arb_rvalid", {31'b0, rvalid}, 32'd1);
    chk("arb_rresp_err", {30'b0, rresp}, 32'd2);
    cyc();
    reg_err = 1'b0;

    // Reset while a write response is pending.
    awaddr = 5'h04; awvalid = 1'b1; wdata = 32'h01020304; wvalid = 1'b1; bready = 1'b0;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    cyc();
    areset = 1'b1;
    smp();
    chk("rstw_bvalid_before", {31'b0, bvalid}, 32'd1);
    chk("rstw_awready_low", {31'b0, awready}, 32'd0);
    cyc();
    areset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rstw_bvalid_gone", {31'b0, bvalid}, 32'd0);
      chk("rstw_no_strobe", {30'b0, reg_wr_en, reg_rd_en}, 32'd0);
      cyc();
    end
    bready = 1'b1;

    // Reset during the read strobe cycle.
    araddr = 5'h1C; arprot = 3'b001; arvalid = 1'b1; reg_rd_data = 32'h77778888;
    cyc();
    arvalid = 1'b0; areset = 1'b1;
    smp();
    chk("rstr_rd_en", {31'b0, reg_rd_en}, 32'd1);
    chk("rstr_arready_low", {31'b0, arready}, 32'd0);
    cyc();
    areset = 1'b0;
    smp();
    chk("rstr_rdata_clear", rdata, 32'd0);
    chk("rstr_addr_clear", {27'b0, reg_addr}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rstr_rvalid_gone", {31'b0, rvalid}, 32'd0);
      chk("rstr_no_strobe", {30'b0, reg_wr_en, reg_rd_en}, 32'd0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
